// File: rtl/ofdm_cp_remover.sv
// OFDM cyclic-prefix remover: locks to a frame-start marker, drops CP_LEN
// prefix samples per symbol, and forwards NFFT samples as an AXI-Stream
// packet with tlast on the final sample. Two-entry output stage (output
// register plus skid) keeps one sample per cycle under backpressure.
module ofdm_cp_remover #(
   parameter int DATA_WIDTH = 32,
   parameter int NFFT       = 1024,
   parameter int CP_LEN     = 256,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  aclk,
   input  logic                  areset,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic                  s_axis_tuser,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic [CNT_WIDTH-1:0]  sym_count,
   output logic                  resync_err
);

   // One extra bit so CP_LEN-1 and NFFT-1 always fit.
   localparam int PW = $clog2(NFFT) + 1;

   typedef enum logic [1:0] {ST_IDLE, ST_SKIP, ST_PASS} state_t;

   localparam logic [PW-1:0] CP_LAST   = PW'(CP_LEN - 1);
   localparam logic [PW-1:0] NFFT_LAST = PW'(NFFT - 1);
   // A sample taken as CP sample 0 completes a one-sample prefix on its own.
   localparam state_t        CP0_NEXT  = (CP_LEN == 1) ? ST_PASS : ST_SKIP;
   localparam logic [PW-1:0] CP0_POS   = (CP_LEN == 1) ? PW'(0) : PW'(1);

   state_t                  state_reg;
   logic [PW-1:0]           pos_reg;
   logic                    resync_err_reg;

   logic [DATA_WIDTH-1:0]   out_data_reg;
   logic                    out_last_reg;
   logic                    out_valid_reg;
   logic [DATA_WIDTH-1:0]   skid_data_reg;
   logic                    skid_last_reg;
   logic                    skid_valid_reg;
   logic [CNT_WIDTH-1:0]    sym_count_reg;

   logic in_xfer;
   logic push;
   logic push_last;
   logic pop;
   logic ready;

   // Input is always accepted outside PASS; in PASS only while the skid is free.
   always_comb begin
      ready = 1'b0;
      if (!areset) begin
         ready = (state_reg != ST_PASS) || !skid_valid_reg;
      end
   end

   assign s_axis_tready = ready;
   assign in_xfer       = s_axis_tvalid & ready;
   // A tuser sample in PASS restarts the CP instead of being forwarded.
   assign push          = in_xfer & (state_reg == ST_PASS) & ~s_axis_tuser;
   assign push_last     = (pos_reg == NFFT_LAST);
   assign pop           = out_valid_reg & m_axis_tready;

   // Framing FSM: tracks position within the prefix or the payload.
   always_ff @(posedge aclk) begin
      if (areset) begin
         state_reg      <= ST_IDLE;
         pos_reg        <= '0;
         resync_err_reg <= 1'b0;
      end else if (in_xfer) begin
         case (state_reg)
            ST_IDLE: begin
               if (s_axis_tuser) begin
                  state_reg <= CP0_NEXT;
                  pos_reg   <= CP0_POS;
               end
            end
            ST_SKIP: begin
               // tuser at prefix position 0 is the expected boundary: ignore it.
               if (s_axis_tuser && pos_reg != '0) begin
                  resync_err_reg <= 1'b1;
                  state_reg      <= CP0_NEXT;
                  pos_reg        <= CP0_POS;
               end else if (pos_reg == CP_LAST) begin
                  state_reg <= ST_PASS;
                  pos_reg   <= '0;
               end else begin
                  pos_reg <= pos_reg + PW'(1);
               end
            end
            ST_PASS: begin
               if (s_axis_tuser) begin
                  resync_err_reg <= 1'b1;
                  state_reg      <= CP0_NEXT;
                  pos_reg        <= CP0_POS;
               end else if (pos_reg == NFFT_LAST) begin
                  state_reg <= ST_SKIP;
                  pos_reg   <= '0;
               end else begin
                  pos_reg <= pos_reg + PW'(1);
               end
            end
            default: begin
               state_reg <= ST_IDLE;
               pos_reg   <= '0;
            end
         endcase
      end
   end

   // Output register plus skid; skid only fills when output is stalled.
   always_ff @(posedge aclk) begin
      if (areset) begin
         out_data_reg   <= '0;
         out_last_reg   <= 1'b0;
         out_valid_reg  <= 1'b0;
         skid_data_reg  <= '0;
         skid_last_reg  <= 1'b0;
         skid_valid_reg <= 1'b0;
         sym_count_reg  <= '0;
      end else begin
         if (!out_valid_reg || pop) begin
            if (skid_valid_reg) begin
               // push cannot coincide: input is held off while the skid is full
               out_data_reg   <= skid_data_reg;
               out_last_reg   <= skid_last_reg;
               out_valid_reg  <= 1'b1;
               skid_valid_reg <= 1'b0;
            end else begin
               out_valid_reg <= push;
               out_last_reg  <= push & push_last;
               if (push) begin
                  out_data_reg <= s_axis_tdata;
               end
            end
         end else if (push) begin
            skid_data_reg  <= s_axis_tdata;
            skid_last_reg  <= push_last;
            skid_valid_reg <= 1'b1;
         end
         if (pop && out_last_reg) begin
            sym_count_reg <= sym_count_reg + CNT_WIDTH'(1);
         end
      end
   end

   assign m_axis_tdata  = out_data_reg;
   assign m_axis_tvalid = out_valid_reg;
   assign m_axis_tlast  = out_last_reg;
   assign sym_count     = sym_count_reg;
   assign resync_err    = resync_err_reg;

endmodule

// File: tb/tb_ofdm_cp_remover.sv
// Scoreboard bench for ofdm_cp_remover: stimulus pushes hand-computed
// expected output beats, an independent monitor pops and compares them.
module tb_ofdm_cp_remover;

   localparam int DW   = 32;
   localparam int NFFT = 1024;
   localparam int CP   = 256;
   localparam int CW   = 16;

   logic          aclk = 1'b0;
   logic          areset = 1'b1;
   logic [DW-1:0] s_tdata = '0;
   logic          s_tvalid = 1'b0;
   logic          s_tready;
   logic          s_tuser = 1'b0;
   logic [DW-1:0] m_tdata;
   logic          m_tvalid;
   logic          m_tready = 1'b1;
   logic          m_tlast;
   logic [CW-1:0] sym_count;
   logic          resync_err;

   ofdm_cp_remover #(
      .DATA_WIDTH(DW), .NFFT(NFFT), .CP_LEN(CP), .CNT_WIDTH(CW)
   ) dut (
      .aclk          (aclk),
      .areset        (areset),
      .s_axis_tdata  (s_tdata),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tready (s_tready),
      .s_axis_tuser  (s_tuser),
      .m_axis_tdata  (m_tdata),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tready (m_tready),
      .m_axis_tlast  (m_tlast),
      .sym_count     (sym_count),
      .resync_err    (resync_err)
   );

   always #5 aclk = ~aclk;

   typedef struct packed {
      logic [DW-1:0] d;
      logic          l;
   } beat_t;

   beat_t exp_q[$];
   int    n_tests = 0;
   int    n_fail  = 0;
   int    out_cnt = 0;
   int    stalls  = 0;
   bit    bp_mode = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   // Downstream ready: always 1, or a random stall pattern in backpressure mode.
   initial begin
      forever begin
         @(posedge aclk);
         #1;
         m_tready = bp_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
      end
   end

   // Monitor: compares every output transfer against the scoreboard.
   initial begin
      logic          prev_stall;
      logic [DW-1:0] prev_d;
      logic          prev_l;
      beat_t         e;
      prev_stall = 1'b0;
      prev_d     = '0;
      prev_l     = 1'b0;
      forever begin
         @(negedge aclk);
         if (areset) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               check("hold_valid", 64'(m_tvalid), 64'(1));
               check("hold_data", 64'(m_tdata), 64'(prev_d));
               check("hold_last", 64'(m_tlast), 64'(prev_l));
            end
            if (!s_tready) begin
               check("tready_low_needs_full_stage", 64'(m_tvalid), 64'(1));
            end
            if (m_tvalid && m_tready) begin
               if (exp_q.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("[TB] FAIL unexpected_out: got data=%0d last=%0b, required no output",
                           m_tdata, m_tlast);
               end else begin
                  e = exp_q.pop_front();
                  $display("[TB] out #%0d data=%0d last=%0b", out_cnt, m_tdata, m_tlast);
                  check("out_data", 64'(m_tdata), 64'(e.d));
                  check("out_last", 64'(m_tlast), 64'(e.l));
               end
               out_cnt++;
            end
            prev_stall = m_tvalid && !m_tready;
            prev_d     = m_tdata;
            prev_l     = m_tlast;
         end
      end
   end

   task automatic send(input int v, input bit u);
      bit rdy;
      int guard;
      guard    = 0;
      s_tdata  = DW'(v);
      s_tuser  = u;
      s_tvalid = 1'b1;
      forever begin
         @(negedge aclk);
         rdy = s_tready;
         @(posedge aclk);
         #1;
         if (rdy) break;
         stalls++;
         guard++;
         if (guard > 1000) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL send_timeout: value %0d not accepted, required acceptance", v);
            break;
         end
      end
      s_tvalid = 1'b0;
      s_tuser  = 1'b0;
   endtask

   task automatic send_range(input int first, input int last, input int u0, input int u1);
      for (int v = first; v <= last; v++) begin
         send(v, (v == u0) || (v == u1));
      end
   endtask

   task automatic push_exp(input int first, input int last, input bit with_last);
      beat_t b;
      for (int v = first; v <= last; v++) begin
         b.d = DW'(v);
         b.l = with_last && (v == last);
         exp_q.push_back(b);
      end
   endtask

   task automatic drain();
      int g;
      g = 0;
      while (exp_q.size() != 0 && g < 5000) begin
         @(posedge aclk);
         g++;
      end
      check("drain_empty", 64'(exp_q.size()), 64'(0));
      repeat (3) @(posedge aclk);
      #1;
      check("idle_after_drain", 64'(m_tvalid), 64'(0));
   endtask

   task automatic do_reset(input int n);
      areset   = 1'b1;
      s_tvalid = 1'b0;
      s_tuser  = 1'b0;
      @(negedge aclk);
      check("reset_tready", 64'(s_tready), 64'(0));
      repeat (n) @(posedge aclk);
      #1;
      areset = 1'b0;
      exp_q.delete();
      out_cnt = 0;
      stalls  = 0;
      check("reset_tvalid", 64'(m_tvalid), 64'(0));
      check("reset_tlast", 64'(m_tlast), 64'(0));
      check("reset_tdata", 64'(m_tdata), 64'(0));
      check("reset_sym_count", 64'(sym_count), 64'(0));
      check("reset_resync_err", 64'(resync_err), 64'(0));
   endtask

   // Global watchdog so the run always ends.
   initial begin
      #3ms;
      $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int v;

      // Nominal: two symbols, continuous flow.
      do_reset(4);
      push_exp(256, 1279, 1'b1);
      push_exp(1536, 2559, 1'b1);
      send_range(0, 256, 0, -1);
      check("latency_valid", 64'(m_tvalid), 64'(1));
      check("latency_data", 64'(m_tdata), 64'(256));
      send_range(257, 1280, -1, -1);
      check("nom_sym_count_1", 64'(sym_count), 64'(1));
      send_range(1281, 2559, -1, -1);
      drain();
      check("nom_sym_count_2", 64'(sym_count), 64'(2));
      check("nom_resync_err", 64'(resync_err), 64'(0));
      check("nom_no_stall", 64'(stalls), 64'(0));

      // Backpressure: random downstream stalls.
      do_reset(4);
      bp_mode = 1'b1;
      push_exp(256, 1279, 1'b1);
      send_range(0, 1279, 0, -1);
      drain();
      bp_mode = 1'b0;
      check("bp_sym_count", 64'(sym_count), 64'(1));

      // Pre-sync junk before the frame marker.
      do_reset(4);
      push_exp(356, 1379, 1'b1);
      send_range(0, 1379, 100, -1);
      drain();
      check("junk_sym_count", 64'(sym_count), 64'(1));
      check("junk_resync_err", 64'(resync_err), 64'(0));

      // Mid-symbol resync on input 756.
      do_reset(4);
      push_exp(256, 755, 1'b0);
      push_exp(1012, 2035, 1'b1);
      send_range(0, 1011, 0, 756);
      check("resync_err_set", 64'(resync_err), 64'(1));
      check("resync_partial_no_count", 64'(sym_count), 64'(0));
      send_range(1012, 2035, -1, -1);
      drain();
      check("resync_sym_count", 64'(sym_count), 64'(1));
      check("resync_err_sticky", 64'(resync_err), 64'(1));

      // tuser on the expected symbol boundary.
      do_reset(4);
      push_exp(256, 1279, 1'b1);
      push_exp(1536, 2559, 1'b1);
      send_range(0, 2559, 0, 1280);
      drain();
      check("bound_resync_err", 64'(resync_err), 64'(0));
      check("bound_sym_count", 64'(sym_count), 64'(2));

      // Reset in the middle of PASS.
      do_reset(4);
      push_exp(256, 1279, 1'b1);
      v = 0;
      while (out_cnt < 300 && v < 2000) begin
         send(v, v == 0);
         v++;
      end
      check("pre_reset_outputs", 64'(out_cnt), 64'(300));
      areset   = 1'b1;
      s_tvalid = 1'b0;
      @(posedge aclk);
      #1;
      areset = 1'b0;
      exp_q.delete();
      check("midreset_tvalid", 64'(m_tvalid), 64'(0));
      check("midreset_sym_count", 64'(sym_count), 64'(0));
      send_range(3000, 3009, -1, -1);
      check("midreset_idle_no_out", 64'(m_tvalid), 64'(0));
      push_exp(4256, 5279, 1'b1);
      send_range(4000, 5279, 4000, -1);
      drain();
      check("midreset_sym_count_after", 64'(sym_count), 64'(1));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
